// File: rtl/rom_loader.sv
// rom_loader: qualifies ioctl download bytes, optionally packs byte pairs, buffers them
// and broadcasts each entry to the SDRAM write ports; also tracks rom_loaded and core reset.
module rom_loader #(
  parameter int               PORTS      = 2,
  parameter logic [PORTS-1:0] PORT_MASK  = '1,
  parameter logic [7:0]       ROM_INDEX  = 8'd0,
  parameter bit               WORD_PACK  = 1'b0,
  parameter int               FIFO_DEPTH = 4,
  parameter int               RESET_HOLD = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  input  logic             user_reset,
  output logic [PORTS-1:0] port_req,
  input  logic [PORTS-1:0] port_ack,
  output logic [22:0]      port_a,
  output logic [1:0]       port_ds,
  output logic [15:0]      port_d,
  output logic             port_we,
  output logic             rom_loaded,
  output logic             core_reset,
  output logic             overflow,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESET_HOLD + 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RESET_HOLD);

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } entry_t;

  // ioctl_addr[24] lies outside the 23-bit word address space.
  logic unused_addr_msb;
  assign unused_addr_msb = ioctl_addr[24];

  logic wr_q, dl_q;
  logic index_ok, strobe, dl_start, dl_fall;
  logic [22:0] byte_a;
  logic        byte_odd;

  assign index_ok = (ioctl_index == ROM_INDEX);
  assign strobe   = ioctl_wr & ~wr_q & ioctl_download & index_ok;
  assign dl_start = ioctl_download & ~dl_q & index_ok;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign byte_a   = ioctl_addr[23:1];
  assign byte_odd = ioctl_addr[0];

  // Edge detectors reset high so a level already present at reset release is not an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= 1'b1;
      dl_q    <= 1'b1;
      port_we <= 1'b0;
    end else begin
      wr_q    <= ioctl_wr;
      dl_q    <= ioctl_download;
      port_we <= ioctl_download & index_ok;
    end
  end

  logic        hold_valid, hold_odd;
  logic [22:0] hold_a;
  logic [7:0]  hold_d;
  logic        hold_load, hold_clear, push;
  entry_t      push_entry, new_single, held_single, pair_entry;

  assign new_single  = {byte_a, byte_odd, ~byte_odd, ioctl_dout, ioctl_dout};
  assign held_single = {hold_a, hold_odd, ~hold_odd, hold_d, hold_d};
  assign pair_entry  = {byte_a, 2'b11, ioctl_dout, hold_d};

  // A mismatched byte displaces the held one, so at most one entry is pushed per cycle.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (!WORD_PACK) begin
      if (strobe) begin
        push       = 1'b1;
        push_entry = new_single;
      end
    end else if (dl_fall && hold_valid) begin
      push       = 1'b1;
      push_entry = held_single;
      hold_clear = 1'b1;
    end else if (strobe) begin
      if (!hold_valid) begin
        if (byte_odd) begin
          push       = 1'b1;
          push_entry = new_single;
        end else begin
          hold_load = 1'b1;
        end
      end else if (byte_odd && !hold_odd && (hold_a == byte_a)) begin
        push       = 1'b1;
        push_entry = pair_entry;
        hold_clear = 1'b1;
      end else begin
        push       = 1'b1;
        push_entry = held_single;
        hold_load  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_odd   <= 1'b0;
      hold_a     <= '0;
      hold_d     <= '0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_odd   <= byte_odd;
      hold_a     <= byte_a;
      hold_d     <= ioctl_dout;
    end else if (hold_clear) begin
      hold_valid <= 1'b0;
    end
  end

  // Port handshake: a masked port is busy while port_req != port_ack. All masked reqs
  // toggle together when an entry is issued; the next issue waits for every masked ack.
  logic outstanding, pop, push_ok, drop, fifo_empty, fifo_full;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  entry_t           mem [FIFO_DEPTH];

  assign outstanding = |((port_req ^ port_ack) & PORT_MASK);
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == FULL_CNT);
  assign pop         = ~fifo_empty & ~outstanding;
  assign push_ok     = push & (~fifo_full | pop);
  assign drop        = push & fifo_full & ~pop;
  assign busy        = ~fifo_empty | outstanding;

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port_req <= '0;
      port_a   <= '0;
      port_ds  <= '0;
      port_d   <= '0;
    end else if (pop) begin
      port_req <= port_req ^ PORT_MASK;
      port_a   <= mem[rd_ptr].a;
      port_ds  <= mem[rd_ptr].ds;
      port_d   <= mem[rd_ptr].d;
    end
  end

  // loading marks a routed download whose completion has not yet been judged.
  logic loading;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      loading    <= 1'b0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else if (dl_start) begin
      loading    <= 1'b1;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (loading && !ioctl_download && fifo_empty && !hold_valid && !outstanding) begin
        loading    <= 1'b0;
        rom_loaded <= ~overflow;
      end
    end
  end

  logic             cause;
  logic [CNT_W-1:0] hold_cnt;

  assign cause      = user_reset | ioctl_download | ~rom_loaded;
  assign core_reset = cause | (hold_cnt != '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)             hold_cnt <= HOLD_INIT;
    else if (cause)           hold_cnt <= HOLD_INIT;
    else if (hold_cnt != '0)  hold_cnt <= hold_cnt - CNT_W'(1);
  end

endmodule
